// File: rtl/removal_sequencer.sv
// removal_sequencer: loads a DEPTH x WIDTH occupancy grid row by row, then
// repeatedly sweeps it, removing every occupied cell with fewer than four
// occupied neighbours, until a sweep removes nothing or MAX_SWEEPS is hit.

// One grid row's sweep: evaluates every cell of cur against the pre-sweep
// rows above and below (out-of-grid rows arrive as zero).
module removal_sequencer_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]               up,
  input  logic [WIDTH-1:0]               cur,
  input  logic [WIDTH-1:0]               dn,
  output logic [WIDTH-1:0]               nxt,
  output logic [$clog2(WIDTH+1)-1:0]     rem
);
  localparam int CW = $clog2(WIDTH+1);

  // zero-padded at both ends so edge columns see empty neighbours
  logic [WIDTH+1:0] up_p, cur_p, dn_p;
  logic [3:0]       nb;

  assign up_p  = {1'b0, up,  1'b0};
  assign cur_p = {1'b0, cur, 1'b0};
  assign dn_p  = {1'b0, dn,  1'b0};

  // count neighbours per column; clear sparse cells and tally removals
  always_comb begin
    nxt = cur;
    rem = '0;
    nb  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      nb = 4'(up_p[j]) + 4'(up_p[j+1]) + 4'(up_p[j+2]) +
           4'(cur_p[j])                + 4'(cur_p[j+2]) +
           4'(dn_p[j]) + 4'(dn_p[j+1]) + 4'(dn_p[j+2]);
      if (cur[j] && nb < 4'd4) begin
        nxt[j] = 1'b0;
        rem    = rem + CW'(1);
      end
    end
  end
endmodule

module removal_sequencer #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int MAX_SWEEPS = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               row_valid,
  input  logic [WIDTH-1:0]                   row_data,
  output logic                               row_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               capped,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]   total_removed,
  output logic [$clog2(MAX_SWEEPS+1)-1:0]    sweep_count,
  input  logic [$clog2(DEPTH)-1:0]           rd_row,
  output logic [WIDTH-1:0]                   rd_data
);
  localparam int RW  = $clog2(DEPTH);
  localparam int TRW = $clog2(WIDTH*DEPTH+1);
  localparam int SCW = $clog2(MAX_SWEEPS+1);
  localparam int RCW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DONE} state_t;

  state_t                        state;
  logic [RW-1:0]                 row_idx;
  logic [DEPTH-1:0][WIDTH-1:0]   grid;
  logic [DEPTH-1:0][WIDTH-1:0]   sweep_nxt;
  logic [DEPTH-1:0][RCW-1:0]     row_rem;
  logic [TRW-1:0]                rem_total;
  logic [SCW-1:0]                sweep_inc;

  // one sweep evaluator per row, all fed from the same pre-sweep grid
  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    logic [WIDTH-1:0] up, dn;
    if (r == 0) begin : g_top
      assign up = '0;
    end else begin : g_up
      assign up = grid[r-1];
    end
    if (r == DEPTH-1) begin : g_bot
      assign dn = '0;
    end else begin : g_dn
      assign dn = grid[r+1];
    end
    removal_sequencer_row #(.WIDTH(WIDTH)) u_row (
      .up  (up),
      .cur (grid[r]),
      .dn  (dn),
      .nxt (sweep_nxt[r]),
      .rem (row_rem[r])
    );
  end

  // total cells removed by the current sweep
  always_comb begin
    rem_total = '0;
    for (int r = 0; r < DEPTH; r++) rem_total = rem_total + TRW'(row_rem[r]);
  end

  assign sweep_inc = sweep_count + SCW'(1);

  // job FSM: load rows, sweep to convergence or cap, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      row_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      capped        <= 1'b0;
      total_removed <= '0;
      sweep_count   <= '0;
      row_idx       <= '0;
      grid          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state         <= S_LOAD;
          row_ready     <= 1'b1;
          busy          <= 1'b1;
          capped        <= 1'b0;
          total_removed <= '0;
          sweep_count   <= '0;
          row_idx       <= '0;
        end
        S_LOAD: if (row_valid) begin
          grid[row_idx] <= row_data;
          row_idx       <= row_idx + RW'(1);
          if (row_idx == RW'(DEPTH-1)) begin
            state     <= S_SWEEP;
            row_ready <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (rem_total == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            grid          <= sweep_nxt;
            total_removed <= total_removed + rem_total;
            sweep_count   <= sweep_inc;
            if (sweep_inc == SCW'(MAX_SWEEPS)) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              capped <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // registered row readout; indices past the grid read as empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rd_data <= '0;
    else if (int'(rd_row) < DEPTH)  rd_data <= grid[rd_row];
    else                            rd_data <= '0;
  end
endmodule

// File: tb/tb_removal_sequencer.sv
// Bench for removal_sequencer: two 4x4 instances (uncapped and MAX_SWEEPS=1)
// share stimulus; expectations come from a neighbour-counting grid model and
// are queued at start, then popped by per-instance monitors on done.
module tb_removal_sequencer;
  localparam int W = 4, D = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, row_valid = 1'b0;
  logic [W-1:0] row_data = '0;
  logic [1:0]   rd_row = '0;
  logic         rr0, bz0, dn0, cp0, rr1, bz1, dn1, cp1;
  logic [4:0]   tr0, tr1;
  logic [6:0]   sc0;
  logic [0:0]   sc1;
  logic [W-1:0] rd0, rd1;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct { int total; int sweeps; int cap; int cyc; } exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic [D-1:0][W-1:0] fin0 = '0, fin1 = '0;

  removal_sequencer #(.WIDTH(W), .DEPTH(D), .MAX_SWEEPS(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid),
    .row_data(row_data), .row_ready(rr0), .busy(bz0), .done(dn0),
    .capped(cp0), .total_removed(tr0), .sweep_count(sc0),
    .rd_row(rd_row), .rd_data(rd0));

  removal_sequencer #(.WIDTH(W), .DEPTH(D), .MAX_SWEEPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid),
    .row_data(row_data), .row_ready(rr1), .busy(bz1), .done(dn1),
    .capped(cp1), .total_removed(tr1), .sweep_count(sc1),
    .rd_row(rd_row), .rd_data(rd1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: repeatedly find every occupied cell with <4 occupied
  // neighbours (in-bounds only), clear them all at once, stop on an empty
  // sweep or once maxs productive sweeps have happened.
  function automatic void model(input logic [D-1:0][W-1:0] in, input int maxs,
                                output int tot, output int swp, output int cap,
                                output logic [D-1:0][W-1:0] fin);
    logic [D-1:0][W-1:0] g, rm;
    int n, nb;
    bit stop;
    g = in; tot = 0; swp = 0; cap = 0; stop = 0;
    for (int it = 0; it < 1000 && !stop; it++) begin
      rm = '0; n = 0;
      for (int r = 0; r < D; r++)
        for (int c = 0; c < W; c++)
          if (g[r][c]) begin
            nb = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < D &&
                    c+dc >= 0 && c+dc < W)
                  nb += int'(g[r+dr][c+dc]);
            if (nb < 4) begin rm[r][c] = 1'b1; n++; end
          end
      if (n == 0) stop = 1;
      else begin
        g = g & ~rm;
        tot += n;
        swp++;
        if (swp == maxs) begin cap = 1; stop = 1; end
      end
    end
    fin = g;
  endfunction

  // monitor for the uncapped instance
  always @(negedge clk) if (rst_n && dn0) begin
    if (q0.size() == 0) begin
      checks++; failures++;
      $display("FAIL dut0_done: got unexpected done pulse, expected none");
    end else begin
      e0 = q0.pop_front();
      chk("dut0_total", int'(tr0), e0.total);
      chk("dut0_sweeps", int'(sc0), e0.sweeps);
      chk("dut0_capped", int'(cp0), e0.cap);
      chk("dut0_done_cycle", cyc, e0.cyc);
    end
  end

  // monitor for the MAX_SWEEPS=1 instance
  always @(negedge clk) if (rst_n && dn1) begin
    if (q1.size() == 0) begin
      checks++; failures++;
      $display("FAIL dut1_done: got unexpected done pulse, expected none");
    end else begin
      e1 = q1.pop_front();
      chk("dut1_total", int'(tr1), e1.total);
      chk("dut1_sweeps", int'(sc1), e1.sweeps);
      chk("dut1_capped", int'(cp1), e1.cap);
      chk("dut1_done_cycle", cyc, e1.cyc);
    end
  end

  task automatic readout();
    for (int r = 0; r < D; r++) begin
      rd_row = 2'(r);
      @(negedge clk);
      chk($sformatf("dut0_rd_row%0d", r), int'(rd0), int'(fin0[r]));
      chk($sformatf("dut1_rd_row%0d", r), int'(rd1), int'(fin1[r]));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   int'(bz0) + int'(bz1), 0);
    chk({tag, "_ready"},  int'(rr0) + int'(rr1), 0);
    chk({tag, "_done"},   int'(dn0) + int'(dn1), 0);
    chk({tag, "_capped"}, int'(cp0) + int'(cp1), 0);
    chk({tag, "_total"},  int'(tr0) + int'(tr1), 0);
    chk({tag, "_sweeps"}, int'(sc0) + int'(sc1), 0);
    chk({tag, "_rd"},     int'(rd0) + int'(rd1), 0);
  endtask

  // mode 0: plain job; 1: start pulsed during SWEEP (all-ones grid only);
  // 2: reset asserted in the first SWEEP cycle
  task automatic run_job(input logic [D-1:0][W-1:0] g, input bit toggle,
                         input int mode);
    exp_t e;
    logic [D-1:0][W-1:0] f;
    int gaps, t;
    gaps = toggle ? D-1 : 0;
    @(negedge clk);
    start = 1'b1;
    model(g, 64, e.total, e.sweeps, e.cap, f);
    fin0 = f;
    e.cyc = cyc + 1 + D + gaps + (e.cap ? e.sweeps : e.sweeps + 1);
    q0.push_back(e);
    model(g, 1, e.total, e.sweeps, e.cap, f);
    fin1 = f;
    e.cyc = cyc + 1 + D + gaps + (e.cap ? e.sweeps : e.sweeps + 1);
    q1.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < D; i++) begin
      chk("load_ready", int'(rr0) + int'(rr1), 2);
      row_valid = 1'b1;
      row_data  = g[i];
      @(negedge clk);
      if (toggle && i < D-1) begin
        row_valid = 1'b0;
        row_data  = W'($urandom);
        chk("stall_ready", int'(rr0) + int'(rr1), 2);
        @(negedge clk);
      end
    end
    row_valid = 1'b0;
    chk("sweep_ready", int'(rr0) + int'(rr1), 0);
    chk("sweep_busy", int'(bz0) + int'(bz1), 2);
    if (mode == 2) begin
      rst_n = 1'b0;
      #1;
      check_zero("abort");
      q0.delete(); q1.delete();
      fin0 = '0; fin1 = '0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check_zero("after_abort");
    end else begin
      if (mode == 1) begin
        start = 1'b1; @(negedge clk);
        start = 1'b1; @(negedge clk);
        start = 1'b0;
      end
      t = 0;
      while ((bz0 || bz1 || dn0 || dn1) && t < 200) begin
        @(negedge clk); t++;
      end
      if (t >= 200) begin
        checks++; failures++;
        $display("FAIL job_timeout: got busy after %0d cycles, expected idle", t);
      end
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(bz0) + int'(bz1), 0);
    end
    readout();
  endtask

  initial begin
    logic [D-1:0][W-1:0] g;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    readout();
    // all-zero grid, valid held high
    g = '0;                    run_job(g, 1'b0, 0);
    // all-ones grid with start poked during SWEEP / DONE
    g = {D{{W{1'b1}}}};        run_job(g, 1'b0, 1);
    rd_row = 2'd0;
    @(negedge clk);
    chk("ones_row0", int'(rd0), 6);
    // single occupied cell
    g = '0; g[2][1] = 1'b1;    run_job(g, 1'b0, 0);
    // gapped load with distinct rows
    g = {4'b1111, 4'b0111, 4'b1110, 4'b1011};
    run_job(g, 1'b1, 0);
    // randomized grids of varying density
    for (int n = 0; n < 16; n++) begin
      case (n % 3)
        0:       g = (D*W)'($urandom);
        1:       g = (D*W)'($urandom | $urandom);
        default: g = (D*W)'($urandom | $urandom | $urandom);
      endcase
      run_job(g, 1'($urandom), 0);
    end
    // reset mid-SWEEP, then a clean job afterwards
    g = {D{{W{1'b1}}}};        run_job(g, 1'b0, 2);
    g = (D*W)'($urandom | $urandom); run_job(g, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
